// File: rtl/lutram_port_arbiter.sv
// lutram_port_arbiter
//   Shares one single-port distributed-RAM buffer among NUM_PORTS requesters
//   (layer engines, loader, readout). Round-robin arbitration with an optional
//   burst lock. The granted port drives the RAM in the same cycle; read data
//   comes back one cycle later with a one-hot rvalid naming the owning port.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req/we/lock         per-port request, write(1)/read(0), burst lock
//   addr, wdata         per-port address / write data, packed port-major
//   gnt                 one-hot grant (combinational)
//   rvalid, rdata       one-hot read-valid (registered), broadcast read data
//   ram_*               single-port RAM interface (registered read data in)
module lutram_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_BITS  = 2,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 784,
  parameter int DEPTH_BITS = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS-1:0]          lock,
  input  logic [NUM_PORTS*DEPTH_BITS-1:0] addr,
  input  logic [NUM_PORTS*WIDTH-1:0]    wdata,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [WIDTH-1:0]              rdata,
  output logic                          ram_write_en,
  output logic                          ram_read_en,
  output logic [DEPTH_BITS-1:0]         ram_write_address,
  output logic [DEPTH_BITS-1:0]         ram_read_address,
  output logic [WIDTH-1:0]              ram_write_data_in,
  input  logic [WIDTH-1:0]              ram_read_data_out
);

  logic [PORT_BITS-1:0]  rr_ptr_reg,   rr_ptr_next;
  logic                  lock_own_reg, lock_own_next;
  logic [PORT_BITS-1:0]  lock_id_reg,  lock_id_next;
  logic [NUM_PORTS-1:0]  rvalid_reg,   rvalid_next;

  logic                  gnt_any;
  logic [PORT_BITS-1:0]  gnt_idx;
  logic                  lock_hold;
  logic [PORT_BITS:0]    cand_sum;
  logic [PORT_BITS-1:0]  cand;

  logic [DEPTH_BITS-1:0] addr_arr  [NUM_PORTS];
  logic [WIDTH-1:0]      wdata_arr [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[gi*DEPTH_BITS +: DEPTH_BITS];
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Grant selection. The lock owner wins while it keeps requesting; otherwise
  // scan from rr_ptr upward (mod NUM_PORTS). The scan runs from the farthest
  // offset down so the nearest requester is the last, winning assignment.
  // No grant is issued while reset is asserted, so the RAM stays idle.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    lock_hold = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    if (rst_n) begin
      if (lock_own_reg && req[lock_id_reg]) begin
        gnt_any   = 1'b1;
        gnt_idx   = lock_id_reg;
        lock_hold = 1'b1;
      end else begin
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
          cand_sum = {1'b0, rr_ptr_reg} + (PORT_BITS+1)'(k);
          if (cand_sum >= (PORT_BITS+1)'(NUM_PORTS))
            cand_sum = cand_sum - (PORT_BITS+1)'(NUM_PORTS);
          cand = cand_sum[PORT_BITS-1:0];
          if (req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
          end
        end
      end
    end
  end

  assign gnt = gnt_any ? (NUM_PORTS'(1) << gnt_idx) : '0;

  // RAM drive from the granted port; buses are zeroed when idle.
  assign ram_write_en      = gnt_any &  we[gnt_idx];
  assign ram_read_en       = gnt_any & ~we[gnt_idx];
  assign ram_write_address = gnt_any ? addr_arr[gnt_idx]  : '0;
  assign ram_read_address  = gnt_any ? addr_arr[gnt_idx]  : '0;
  assign ram_write_data_in = gnt_any ? wdata_arr[gnt_idx] : '0;

  assign rdata  = ram_read_data_out;
  assign rvalid = rvalid_reg;

  always_comb begin
    rr_ptr_next   = rr_ptr_reg;
    lock_own_next = lock_own_reg;
    lock_id_next  = lock_id_reg;
    rvalid_next   = ram_read_en ? gnt : '0;
    if (gnt_any) begin
      // A grant that merely continues a burst does not advance fairness.
      if (!lock_hold)
        rr_ptr_next = (gnt_idx == PORT_BITS'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      lock_own_next = lock[gnt_idx];
      if (lock[gnt_idx])
        lock_id_next = gnt_idx;
    end else begin
      // No grant at all implies the owner (if any) dropped its request.
      lock_own_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg   <= '0;
      lock_own_reg <= 1'b0;
      lock_id_reg  <= '0;
      rvalid_reg   <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      lock_own_reg <= lock_own_next;
      lock_id_reg  <= lock_id_next;
      rvalid_reg   <= rvalid_next;
    end
  end

endmodule

// File: tb/tb_lutram_port_arbiter.sv
// Testbench for lutram_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model (grant rules, reference memory, expected read returns).
module tb_lutram_port_arbiter;
  localparam int N  = 4;
  localparam int PB = 2;
  localparam int W  = 8;
  localparam int D  = 784;
  localparam int AB = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we, lock;
  logic [N*AB-1:0] addr;
  logic [N*W-1:0]  wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [W-1:0]    rdata;
  logic            ram_write_en, ram_read_en;
  logic [AB-1:0]   ram_write_address, ram_read_address;
  logic [W-1:0]    ram_write_data_in, ram_read_data_out;

  int errors = 0;
  int checks = 0;
  bit verbose = 1'b1;

  always #5 clk = ~clk;

  lutram_port_arbiter #(
    .NUM_PORTS(N), .PORT_BITS(PB), .WIDTH(W), .DEPTH(D), .DEPTH_BITS(AB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
    .ram_write_address(ram_write_address), .ram_read_address(ram_read_address),
    .ram_write_data_in(ram_write_data_in), .ram_read_data_out(ram_read_data_out)
  );

  function automatic logic [W-1:0] init_val(input int a);
    return W'((a * 37 + 11) & 255);
  endfunction

  // Bench-side single-port RAM with registered read.
  logic [W-1:0] mem [D];
  bit ram_inited = 1'b0;
  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int a = 0; a < D; a++) mem[a] = init_val(a);
      ram_inited = 1'b1;
    end
    if (ram_write_en) mem[ram_write_address] = ram_write_data_in;
    if (ram_read_en) ram_read_data_out <= mem[ram_read_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_ptr = 0;
  bit           m_lock_own = 0;
  int           m_lock_id = 0;
  logic [N-1:0] exp_rvalid = '0;
  logic [W-1:0] exp_rdata = '0;
  logic [W-1:0] refmem [D];
  bit           ref_inited = 1'b0;

  always @(negedge clk) begin
    int g;
    bit via_lock;
    int ga;
    if (!ref_inited) begin
      for (int a = 0; a < D; a++) refmem[a] = init_val(a);
      ref_inited = 1'b1;
    end
    if (!rst_n) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_en", {ram_write_en, ram_read_en}, 0);
      m_ptr = 0; m_lock_own = 0; m_lock_id = 0; exp_rvalid = '0;
    end else begin
      chk("rvalid", rvalid, exp_rvalid);
      if (exp_rvalid != 0) chk("rdata", rdata, exp_rdata);
      g = -1;
      via_lock = 0;
      if (m_lock_own && req[m_lock_id]) begin
        g = m_lock_id;
        via_lock = 1;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      chk("gnt", gnt, (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("excl", ram_write_en & ram_read_en, 0);
      if (g >= 0) begin
        ga = int'(addr[g*AB +: AB]);
        chk("wen", ram_write_en, we[g]);
        chk("ren", ram_read_en, !we[g]);
        chk("waddr", ram_write_address, ga);
        chk("raddr", ram_read_address, ga);
        chk("wdin", ram_write_data_in, wdata[g*W +: W]);
        if (verbose)
          $display("txn port=%0d %s addr=%0d data=%02h", g, we[g] ? "WR" : "RD", ga,
                   we[g] ? wdata[g*W +: W] : refmem[ga]);
        if (we[g]) begin
          refmem[ga] = wdata[g*W +: W];
          exp_rvalid = '0;
        end else begin
          exp_rdata  = refmem[ga];
          exp_rvalid = N'(1) << g;
        end
        if (!via_lock) m_ptr = (g + 1) % N;
        m_lock_own = lock[g];
        if (lock[g]) m_lock_id = g;
      end else begin
        chk("idle_bus", {ram_write_en, ram_read_en, ram_write_address, ram_read_address,
                         ram_write_data_in}, 0);
        exp_rvalid = '0;
        m_lock_own = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    chk(name, act_sel, exp);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input bit r, input bit w, input bit l,
                          input int a, input int d);
    req[i]  = r;
    we[i]   = w;
    lock[i] = l;
    addr[i*AB +: AB] = AB'(a);
    wdata[i*W +: W]  = W'(d);
  endtask

  task automatic clear_ports();
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    clear_ports();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] g_seen;
    clear_ports();
    rst_n = 1'b0;

    // Reset with all ports requesting: nothing granted, RAM idle.
    req = 4'b1111;
    tick();
    at_neg();
    lit("L_rst_gnt", gnt, 4'b0000);
    lit("L_rst_en", {ram_write_en, ram_read_en}, 2'b00);
    tick();
    rst_n = 1'b1;
    at_neg();
    lit("L_first_gnt", gnt, 4'b0001);

    // Single port write then read.
    do_reset();
    set_port(2, 1, 1, 0, 5, 8'hA5);
    at_neg();
    lit("L_wr_gnt", gnt, 4'b0100);
    lit("L_wr_en", ram_write_en, 1'b1);
    tick();
    set_port(2, 1, 0, 0, 5, 0);
    at_neg();
    lit("L_rd_gnt", gnt, 4'b0100);
    tick();
    clear_ports();
    at_neg();
    lit("L_rd_valid", rvalid, 4'b0100);
    lit("L_rd_data", rdata, 8'hA5);

    // Round-robin with all ports reading.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      at_neg();
      lit("L_rr_gnt", gnt, 32'd1 << (k % 4));
      if (k > 0) lit("L_rr_rvalid", rvalid, 32'd1 << ((k - 1) % 4));
      tick();
    end
    clear_ports();

    // Burst lock on port 1 with ports 0 and 3 contending.
    do_reset();
    set_port(0, 1, 0, 0, 1, 0);
    at_neg();
    lit("L_lk_pre", gnt, 4'b0001);
    tick();
    set_port(1, 1, 0, 1, 2, 0);
    set_port(3, 1, 0, 0, 3, 0);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      lit("L_lk_hold", gnt, 4'b0010);
      tick();
    end
    lock[1] = 1'b0;
    at_neg();
    lit("L_lk_last", gnt, 4'b0010);
    tick();
    req[1] = 1'b0;
    at_neg();
    lit("L_lk_p3", gnt, 4'b1000);
    tick();
    req[3] = 1'b0;
    at_neg();
    lit("L_lk_p0", gnt, 4'b0001);
    tick();
    clear_ports();

    // Reset right after a read grant: read is dropped, pointer restarts.
    do_reset();
    set_port(2, 1, 0, 0, 7, 0);
    at_neg();
    lit("L_mr_gnt", gnt, 4'b0100);
    tick();
    clear_ports();
    rst_n = 1'b0;
    at_neg();
    lit("L_mr_rvalid0", rvalid, 4'b0000);
    tick();
    rst_n = 1'b1;
    req = 4'b1111;
    at_neg();
    lit("L_mr_rvalid1", rvalid, 4'b0000);
    lit("L_mr_ptr", gnt, 4'b0001);
    tick();
    clear_ports();
    tick();

    // Randomized traffic; requests held until granted.
    verbose = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      g_seen = gnt;
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req[i] || g_seen[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_port(i, 1, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, D - 1) : $urandom_range(0, 15),
                     $urandom_range(0, 255));
          else
            req[i] = 1'b0;
        end
      end
    end
    clear_ports();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
